sdram_access_ctrl: RTL and testbench

Bridges the control unit's single-cycle SDRAM command pulses to an Avalon-MM master port on the SDRAM controller. On completion it returns the `dataRead_sdram` / write-done handshakes that the control unit waits on. It sits directly downstream of the control unit and the SDRAM address calculator, and upstream of the window buffer, which consumes `rdata`. It holds one pending request, bounds read latency with a timeout, and reports overrun and timeout as sticky flags.

---
 rtl/sdram_if_pkg.sv | 25 ++
 rtl/sdram_access_ctrl_slot.sv | 61 ++++++
 rtl/sdram_access_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sdram_access_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_if_pkg.sv
// Shared definitions for the SDRAM access path between the control unit
// and the Avalon-MM master port of the SDRAM controller.
//
// Contents:
//   DEF_ADDR_W / DEF_DATA_W : default word address and data widths
//   sdram_state_t           : access FSM states
//   sdram_op_t              : request kind held in the pending slot
package sdram_if_pkg;

   localparam int DEF_ADDR_W = 24;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_REQ  = 2'd1,
      RD_WAIT = 2'd2,
      WR_REQ  = 2'd3
   } sdram_state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } sdram_op_t;

endpackage

// File: rtl/sdram_access_ctrl_slot.sv
// One-deep pending request register (sdram_req_slot) for the SDRAM
// access controller. Holds a single deferred read or write together with
// its address and write data, and keeps the sticky overrun flag that
// records any request that could not be stored.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load                : capture load_wr/load_addr/load_data, mark full
//   load_wr             : 1 = write request, 0 = read request
//   load_addr/load_data : request address and write data
//   clear               : request launched, mark empty
//   drop                : a request was discarded, set overrun
//   valid               : slot holds a request
//   is_wr, addr, data   : stored request
//   overrun             : sticky drop flag, cleared only by rst
module sdram_req_slot
   import sdram_if_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              load_wr,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   input  logic              clear,
   input  logic              drop,
   output logic              valid,
   output logic              is_wr,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data,
   output logic              overrun
);

   // A load on the same edge as a clear refills the slot: the old entry
   // is being launched while the new pulse takes its place.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid   <= 1'b0;
         is_wr   <= 1'b0;
         addr    <= '0;
         data    <= '0;
         overrun <= 1'b0;
      end else begin
         if (load) begin
            valid <= 1'b1;
            is_wr <= load_wr;
            addr  <= load_addr;
            data  <= load_data;
         end else if (clear) begin
            valid <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sdram_access_ctrl.sv
// Bridges single-cycle read/write pulses from the control unit onto an
// Avalon-MM master port and returns dataRead_sdram / write_done
// completion pulses. One extra request can be parked in a pending slot;
// reads are bounded by a timeout so the control unit never stalls.
//
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   read_en_sdram, write_en_sdram   : request pulses
//   addr_sdram, wdata               : request address / write data
//   avm_address, avm_read,
//   avm_write, avm_writedata        : Avalon master command (registered)
//   avm_waitrequest, avm_readdata,
//   avm_readdatavalid               : Avalon slave response
//   dataRead_sdram, rdata           : read completion pulse and data
//   write_done                      : write accepted pulse
//   busy                            : not idle or pending slot full
//   overrun, timeout                : sticky error flags
module sdram_access_ctrl
   import sdram_if_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read_en_sdram,
   input  logic              write_en_sdram,
   input  logic [ADDR_W-1:0] addr_sdram,
   input  logic [DATA_W-1:0] wdata,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              dataRead_sdram,
   output logic [DATA_W-1:0] rdata,
   output logic              write_done,
   output logic              busy,
   output logic              overrun,
   output logic              timeout
);

   localparam int               CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   sdram_state_t      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] avm_address_d;
   logic              avm_read_d, avm_write_d;
   logic [DATA_W-1:0] avm_writedata_d, rdata_d;
   logic              data_read_d, write_done_d, busy_d, timeout_d;

   logic              slot_load, slot_load_wr, slot_clear, slot_drop;
   logic              slot_valid, slot_is_wr;
   logic [ADDR_W-1:0] slot_addr;
   logic [DATA_W-1:0] slot_data;
   sdram_op_t         slot_op;

   logic              rd_left, wr_left, slot_free;

   sdram_req_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load),
      .load_wr   (slot_load_wr),
      .load_addr (addr_sdram),
      .load_data (wdata),
      .clear     (slot_clear),
      .drop      (slot_drop),
      .valid     (slot_valid),
      .is_wr     (slot_is_wr),
      .addr      (slot_addr),
      .data      (slot_data),
      .overrun   (overrun)
   );

   assign slot_op = slot_is_wr ? OP_WR : OP_RD;

   // State and every output are registered here; the next values all come
   // from the combinational block below, so reset clears strobes and
   // completion pulses on the very edge it is sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         avm_address    <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= '0;
         rdata          <= '0;
         dataRead_sdram <= 1'b0;
         write_done     <= 1'b0;
         busy           <= 1'b0;
         timeout        <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         avm_address    <= avm_address_d;
         avm_read       <= avm_read_d;
         avm_write      <= avm_write_d;
         avm_writedata  <= avm_writedata_d;
         rdata          <= rdata_d;
         dataRead_sdram <= data_read_d;
         write_done     <= write_done_d;
         busy           <= busy_d;
         timeout        <= timeout_d;
      end
   end

   // Next-state and next-output logic. rd_left / wr_left track pulses that
   // were not launched directly from IDLE and therefore need the pending
   // slot; a read always takes precedence for the single free entry.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      avm_address_d   = avm_address;
      avm_read_d      = avm_read;
      avm_write_d     = avm_write;
      avm_writedata_d = avm_writedata;
      rdata_d         = rdata;
      data_read_d     = 1'b0;
      write_done_d    = 1'b0;
      timeout_d       = timeout;
      slot_load       = 1'b0;
      slot_load_wr    = 1'b0;
      slot_clear      = 1'b0;
      slot_drop       = 1'b0;
      rd_left         = read_en_sdram;
      wr_left         = write_en_sdram;
      slot_free       = 1'b0;
      busy_d          = 1'b0;

      case (state_q)
         IDLE: begin
            if (slot_valid) begin
               slot_clear    = 1'b1;
               avm_address_d = slot_addr;
               if (slot_op == OP_WR) begin
                  avm_write_d     = 1'b1;
                  avm_writedata_d = slot_data;
                  state_d         = WR_REQ;
               end else begin
                  avm_read_d = 1'b1;
                  state_d    = RD_REQ;
               end
            end else if (read_en_sdram) begin
               rd_left       = 1'b0;
               avm_address_d = addr_sdram;
               avm_read_d    = 1'b1;
               state_d       = RD_REQ;
            end else if (write_en_sdram) begin
               wr_left         = 1'b0;
               avm_address_d   = addr_sdram;
               avm_writedata_d = wdata;
               avm_write_d     = 1'b1;
               state_d         = WR_REQ;
            end
         end
         RD_REQ: begin
            if (!avm_waitrequest) begin
               avm_read_d = 1'b0;
               cnt_d      = '0;
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // Valid data wins over an abort landing on the same edge.
            if (avm_readdatavalid) begin
               rdata_d     = avm_readdata;
               data_read_d = 1'b1;
               state_d     = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d   = 1'b1;
               rdata_d     = '0;
               data_read_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_REQ: begin
            if (!avm_waitrequest) begin
               avm_write_d  = 1'b0;
               write_done_d = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // The slot entry launched this edge frees its place for a new pulse.
      slot_free = !slot_valid || slot_clear;
      if (rd_left) begin
         if (slot_free) begin
            slot_load    = 1'b1;
            slot_load_wr = 1'b0;
         end else begin
            slot_drop = 1'b1;
         end
         if (wr_left) begin
            slot_drop = 1'b1;
         end
      end else if (wr_left) begin
         if (slot_free) begin
            slot_load    = 1'b1;
            slot_load_wr = 1'b1;
         end else begin
            slot_drop = 1'b1;
         end
      end

      busy_d = (state_d != IDLE) || slot_load || (slot_valid && !slot_clear);
   end

endmodule

// File: tb/tb_sdram_access_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sdram_access_ctrl: a cycle table for the basic
// read and write, hand sequences for the multi-cycle corner cases, then
// randomized traffic against a transaction-level reference model.
module tb_sdram_access_ctrl;

   localparam int ADDR_W  = 24;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 64;

   logic              clk;
   logic              rst;
   logic              read_en_sdram, write_en_sdram;
   logic [ADDR_W-1:0] addr_sdram;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] avm_address;
   logic              avm_read, avm_write;
   logic [DATA_W-1:0] avm_writedata;
   logic              avm_waitrequest;
   logic [DATA_W-1:0] avm_readdata;
   logic              avm_readdatavalid;
   logic              dataRead_sdram;
   logic [DATA_W-1:0] rdata;
   logic              write_done, busy, overrun, timeout;

   int nvec = 0;
   int nmis = 0;

   typedef struct {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              wq;
      logic              rdv;
      logic [DATA_W-1:0] rdin;
      logic              e_read;
      logic              e_write;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      logic              e_dr;
      logic [DATA_W-1:0] e_rdata;
      logic              e_wd;
      logic              e_busy;
   } vec_t;

   typedef struct {
      logic              is_wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } txn_t;

   vec_t vecs[11];
   txn_t q[$];
   txn_t t;

   logic              rd_inflight, exp_dr, exp_wd, full_idle;
   logic              prev_rd, prev_wr, prev_wq, wq, rdv, rd_en, wr_en;
   logic [DATA_W-1:0] rd_word, exp_rdata, rdin, rnd_d;
   logic [ADDR_W-1:0] rnd_a;
   int                lat, kind, waited;
   logic              found;

   sdram_access_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .read_en_sdram     (read_en_sdram),
      .write_en_sdram    (write_en_sdram),
      .addr_sdram        (addr_sdram),
      .wdata             (wdata),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .dataRead_sdram    (dataRead_sdram),
      .rdata             (rdata),
      .write_done        (write_done),
      .busy              (busy),
      .overrun           (overrun),
      .timeout           (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic w, input logic v,
                                input logic [DATA_W-1:0] rin);
      read_en_sdram     = rd;
      write_en_sdram    = wr;
      addr_sdram        = a;
      wdata             = d;
      avm_waitrequest   = w;
      avm_readdatavalid = v;
      avm_readdata      = rin;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " avm_address"}, avm_address, 0);
      checkOutput({tag, " avm_read"}, avm_read, 0);
      checkOutput({tag, " avm_write"}, avm_write, 0);
      checkOutput({tag, " avm_writedata"}, avm_writedata, 0);
      checkOutput({tag, " rdata"}, rdata, 0);
      checkOutput({tag, " dataRead"}, dataRead_sdram, 0);
      checkOutput({tag, " write_done"}, write_done, 0);
      checkOutput({tag, " busy"}, busy, 0);
      checkOutput({tag, " overrun"}, overrun, 0);
      checkOutput({tag, " timeout"}, timeout, 0);
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

      // Basic read (2 waitrequest cycles, data 3 cycles after accept)
      // followed by a zero-wait write.
      vecs[0]  = '{1'b1, 1'b0, 24'h10, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 24'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 24'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 24'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'h10, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 24'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'h10, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 24'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 24'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 24'h0,  32'h0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 24'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};

      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
                       vecs[i].wq, vecs[i].rdv, vecs[i].rdin);
         tick();
         checkOutput($sformatf("tbl%0d avm_read", i), avm_read, vecs[i].e_read);
         checkOutput($sformatf("tbl%0d avm_write", i), avm_write, vecs[i].e_write);
         checkOutput($sformatf("tbl%0d avm_address", i), avm_address, vecs[i].e_addr);
         checkOutput($sformatf("tbl%0d avm_writedata", i), avm_writedata, vecs[i].e_wdata);
         checkOutput($sformatf("tbl%0d dataRead", i), dataRead_sdram, vecs[i].e_dr);
         checkOutput($sformatf("tbl%0d rdata", i), rdata, vecs[i].e_rdata);
         checkOutput($sformatf("tbl%0d write_done", i), write_done, vecs[i].e_wd);
         checkOutput($sformatf("tbl%0d busy", i), busy, vecs[i].e_busy);
         checkOutput($sformatf("tbl%0d overrun", i), overrun, 0);
      end

      // Simultaneous read and write: read first, write from pending slot.
      applyStimulus(1'b1, 1'b1, 24'h30, 32'hA5A5A5A5, 1'b0, 1'b0, '0);
      tick();
      checkOutput("dual read strobe", avm_read, 1);
      checkOutput("dual read addr", avm_address, 24'h30);
      checkOutput("dual no write yet", avm_write, 0);
      applyStimulus(1'b0, 1'b0, 24'hFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
      tick();
      checkOutput("dual read accepted", avm_read, 0);
      applyStimulus(1'b0, 1'b0, 24'hFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h11112222);
      tick();
      checkOutput("dual dataRead", dataRead_sdram, 1);
      checkOutput("dual rdata", rdata, 32'h11112222);
      checkOutput("dual write waits", avm_write, 0);
      checkOutput("dual busy pending", busy, 1);
      applyStimulus(1'b0, 1'b0, 24'hFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
      tick();
      checkOutput("dual write strobe", avm_write, 1);
      checkOutput("dual write addr", avm_address, 24'h30);
      checkOutput("dual write data", avm_writedata, 32'hA5A5A5A5);
      checkOutput("dual dataRead single", dataRead_sdram, 0);
      tick();
      checkOutput("dual write_done", write_done, 1);
      checkOutput("dual write dropped", avm_write, 0);
      checkOutput("dual overrun", overrun, 0);

      // Three pulses while a read is stalled: first parked, rest dropped.
      applyStimulus(1'b1, 1'b0, 24'h40, 32'h0, 1'b1, 1'b0, '0);
      tick();
      checkOutput("ovr read strobe", avm_read, 1);
      applyStimulus(1'b0, 1'b1, 24'h50, 32'hCAFEF00D, 1'b1, 1'b0, '0);
      tick();
      checkOutput("ovr first queued", overrun, 0);
      checkOutput("ovr busy", busy, 1);
      applyStimulus(1'b1, 1'b0, 24'h60, 32'h0, 1'b1, 1'b0, '0);
      tick();
      checkOutput("ovr second dropped", overrun, 1);
      applyStimulus(1'b0, 1'b1, 24'h70, 32'h77, 1'b1, 1'b0, '0);
      tick();
      checkOutput("ovr read still held", avm_read, 1);
      checkOutput("ovr addr stable", avm_address, 24'h40);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h44);
      tick();
      checkOutput("ovr dataRead", dataRead_sdram, 1);
      checkOutput("ovr rdata", rdata, 32'h44);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      checkOutput("ovr queued write strobe", avm_write, 1);
      checkOutput("ovr queued write addr", avm_address, 24'h50);
      checkOutput("ovr queued write data", avm_writedata, 32'hCAFEF00D);
      tick();
      checkOutput("ovr write_done", write_done, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("ovr no extra read", avm_read, 0);
         checkOutput("ovr no extra write", avm_write, 0);
         checkOutput("ovr sticky", overrun, 1);
      end

      // Read with no readdatavalid: abort after TIMEOUT cycles in RD_WAIT.
      applyStimulus(1'b1, 1'b0, 24'h80, 32'h0, 1'b0, 1'b0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      checkOutput("to flag clear before", timeout, 0);
      found  = 1'b0;
      waited = 0;
      for (int n = 1; n <= TIMEOUT + 20 && !found; n++) begin
         tick();
         if (dataRead_sdram) begin
            found  = 1'b1;
            waited = n;
         end
      end
      checkOutput("to abort latency", waited, TIMEOUT);
      checkOutput("to flag", timeout, 1);
      checkOutput("to rdata zero", rdata, 0);
      checkOutput("to busy", busy, 0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h999);
      tick();
      checkOutput("to late valid ignored", dataRead_sdram, 0);
      checkOutput("to late rdata ignored", rdata, 0);
      checkOutput("to flag sticky", timeout, 1);

      // Reset while waiting for read data.
      applyStimulus(1'b1, 1'b0, 24'h90, 32'h0, 1'b0, 1'b0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      rst = 1'b1;
      tick();
      checkAllZero("midrst");
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h5555);
      tick();
      checkOutput("midrst late dataRead", dataRead_sdram, 0);
      checkOutput("midrst late rdata", rdata, 0);
      checkOutput("midrst busy", busy, 0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      tick();
      checkOutput("midrst no pulse", dataRead_sdram, 0);

      // Randomized traffic. The model keeps the ordered list of requests
      // that must appear on the Avalon bus, a random-latency slave, and the
      // completion pulses each accepted command must produce.
      rd_inflight = 1'b0;
      exp_dr      = 1'b0;
      exp_wd      = 1'b0;
      prev_rd     = 1'b0;
      prev_wr     = 1'b0;
      prev_wq     = 1'b0;
      lat         = 0;
      rd_word     = '0;
      exp_rdata   = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         checkOutput("rnd dataRead", dataRead_sdram, exp_dr);
         if (exp_dr) checkOutput("rnd rdata", rdata, exp_rdata);
         checkOutput("rnd write_done", write_done, exp_wd);
         checkOutput("rnd busy", busy, (q.size() > 0) || rd_inflight);
         if (prev_rd && prev_wq) checkOutput("rnd read held", avm_read, 1);
         if (prev_wr && prev_wq) checkOutput("rnd write held", avm_write, 1);
         if (avm_read && avm_write) checkOutput("rnd both strobes", 2'b11, 2'b01);
         exp_dr = 1'b0;
         exp_wd = 1'b0;

         rdv  = 1'b0;
         rdin = $urandom;
         if (rd_inflight) begin
            if (lat == 0) begin
               rdv         = 1'b1;
               rdin        = rd_word;
               exp_dr      = 1'b1;
               exp_rdata   = rd_word;
               rd_inflight = 1'b0;
            end else begin
               lat--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            rdv = 1'b1;
         end

         wq = ($urandom_range(0, 2) == 0);
         if ((avm_read || avm_write) && !wq) begin
            checkOutput("rnd command expected", q.size() != 0, 1);
            if (q.size() != 0) begin
               t = q.pop_front();
               checkOutput("rnd op", avm_write, t.is_wr);
               checkOutput("rnd addr", avm_address, t.addr);
               if (t.is_wr) begin
                  checkOutput("rnd wdata", avm_writedata, t.data);
                  exp_wd = 1'b1;
               end else begin
                  rd_inflight = 1'b1;
                  lat         = $urandom_range(0, 4);
                  rd_word     = $urandom;
               end
            end
         end

         rd_en     = 1'b0;
         wr_en     = 1'b0;
         rnd_a     = ADDR_W'($urandom);
         rnd_d     = $urandom;
         full_idle = (q.size() == 0) && !rd_inflight && !exp_dr && !exp_wd && !avm_read && !avm_write;
         if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
            kind = $urandom_range(0, 2);
            if (kind == 2 && full_idle) begin
               rd_en = 1'b1;
               wr_en = 1'b1;
               q.push_back('{1'b0, rnd_a, rnd_d});
               q.push_back('{1'b1, rnd_a, rnd_d});
            end else if (kind == 0) begin
               rd_en = 1'b1;
               q.push_back('{1'b0, rnd_a, rnd_d});
            end else begin
               wr_en = 1'b1;
               q.push_back('{1'b1, rnd_a, rnd_d});
            end
         end

         prev_rd = avm_read;
         prev_wr = avm_write;
         prev_wq = wq;
         applyStimulus(rd_en, wr_en, rnd_a, rnd_d, wq, rdv, rdin);
         tick();
      end
      checkOutput("rnd overrun", overrun, 0);
      checkOutput("rnd timeout", timeout, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
